relu_maxpool_2x2: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage directly downstream of the CNN ReLU output.
- Consumes the ReLU pixel stream (signed 32-bit, raster order, one feature map) over a valid/ready handshake.
- Emits one pooled pixel per 2x2 window over a valid/ready handshake to the output writer.
- A half-width line buffer holds the horizontal-pair maxima of each even row.

---
 rtl/relu_maxpool_2x2.sv | 118 +++++++++++
 tb/tb_relu_maxpool_2x2.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: streaming 2x2 / stride-2 max pooling behind the ReLU stage.
// Even rows fold horizontal pairs into a half-width line buffer. Odd rows combine
// their own pair with the stored pair maximum and load a one-entry output register.
module relu_maxpool_2x2 #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              frame_done_o
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D = IMG_W / 2;
  localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_frame_done;
  logic [DATA_W-1:0] r_linebuf [LB_D];

  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_odd_row;
  logic              w_odd_col;
  logic              w_pool_load;
  logic              w_lb_write;
  logic [LBW-1:0]    w_lb_idx;
  logic [DATA_W-1:0] w_lb_rd;
  logic [DATA_W-1:0] w_pair_max;
  logic [DATA_W-1:0] w_pool_max;

  function automatic logic [DATA_W-1:0] f_smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Handshake, position decode and the pooling datapath.
  always_comb begin
    in_ready_o  = !r_out_valid || out_ready_i;
    // Abort wins over a beat presented in the same cycle: that beat is not consumed.
    w_accept    = in_valid_i && in_ready_o && !clear_i;
    w_last_col  = (r_col == CW'(IMG_W - 1));
    w_last_row  = (r_row == RW'(IMG_H - 1));
    w_odd_row   = r_row[0];
    w_odd_col   = r_col[0];
    w_lb_idx    = LBW'(r_col >> 1);
    w_lb_rd     = r_linebuf[w_lb_idx];
    w_pair_max  = f_smax(r_hold, in_data_i);
    w_pool_max  = f_smax(w_lb_rd, w_pair_max);
    w_pool_load = w_accept && w_odd_row && w_odd_col;
    w_lb_write  = w_accept && !w_odd_row && w_odd_col;
  end

  // Column/row counters, the even-column hold register and the end-of-frame pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_frame_done <= 1'b0;
    end else if (clear_i) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_last_col && w_last_row;
      if (w_accept) begin
        if (!w_odd_col) r_hold <= in_data_i;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Line buffer: no reset needed, each entry is written on an even row before its odd-row read.
  always_ff @(posedge clk_i) begin
    if (w_lb_write) r_linebuf[w_lb_idx] <= w_pair_max;
  end

  // One-entry output register; a new pooled pixel may replace one leaving on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear_i) begin
      r_out_valid <= 1'b0;
    end else if (w_pool_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_pool_max;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data_o   = r_out_data;
  assign out_valid_o  = r_out_valid;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Bench for relu_maxpool_2x2: a 4x4 and a 5x5 instance share one stimulus driver.
// Expected pooled pixels are computed per whole frame and compared in order.
module tb_relu_maxpool_2x2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clear;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        rdy4, ov4, fd4, rdy5, ov5, fd5;
  logic [31:0] od4, od5;

  int n_checks = 0;
  int n_errors = 0;
  int q_in[$];
  int q_exp[$];
  int pix_cnt = 0;
  bit exp_fd = 1'b0;
  bit stalled_prev = 1'b0;
  logic [31:0] prev_od = '0;

  relu_maxpool_2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid && !sel), .in_ready_o(rdy4),
    .out_data_o(od4), .out_valid_o(ov4), .out_ready_i(out_ready),
    .frame_done_o(fd4)
  );

  relu_maxpool_2x2 #(.DATA_W(32), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid && sel), .in_ready_o(rdy5),
    .out_data_o(od5), .out_valid_o(ov5), .out_ready_i(out_ready),
    .frame_done_o(fd5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic int img_w();
    return sel ? 5 : 4;
  endfunction

  function automatic int img_h();
    return sel ? 5 : 4;
  endfunction

  // Reference: queue the frame and the max of every complete 2x2 window in raster order.
  task automatic push_frame(input int f[$]);
    int w, h, m;
    w = img_w();
    h = img_h();
    foreach (f[i]) q_in.push_back(f[i]);
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        m = f[(2*r)*w + 2*c];
        if (f[(2*r)*w + 2*c + 1] > m)   m = f[(2*r)*w + 2*c + 1];
        if (f[(2*r+1)*w + 2*c] > m)     m = f[(2*r+1)*w + 2*c];
        if (f[(2*r+1)*w + 2*c + 1] > m) m = f[(2*r+1)*w + 2*c + 1];
        q_exp.push_back(m);
      end
    end
  endtask

  task automatic push_ramp();
    int f[$];
    for (int i = 0; i < img_w() * img_h(); i++) f.push_back(i);
    push_frame(f);
  endtask

  task automatic push_random();
    int f[$];
    for (int i = 0; i < img_w() * img_h(); i++) f.push_back(int'($urandom));
    push_frame(f);
  endtask

  // Drive queued pixels with random valid/ready rates; stop after max_acc beats (<0: drain all).
  task automatic run(input int pv, input int pr, input int max_acc);
    int acc_cnt;
    int cyc;
    bit acc;
    logic rdy, ov, fd;
    logic [31:0] od;
    acc_cnt = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (q_in.size() > 0) && ($urandom_range(99) < pv);
      in_data   = in_valid ? q_in[0] : $urandom;
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      rdy = sel ? rdy5 : rdy4;
      ov  = sel ? ov5  : ov4;
      od  = sel ? od5  : od4;
      fd  = sel ? fd5  : fd4;
      chk("frame_done", fd, exp_fd);
      chk("in_ready", rdy, !ov || out_ready);
      if (stalled_prev) begin
        chk("stall_valid", ov, 1'b1);
        chk("stall_data", od, prev_od);
      end
      if (ov && out_ready) begin
        if (q_exp.size() == 0) chk("extra_output", ov, 1'b0);
        else chk("out_data", od, q_exp.pop_front());
      end
      acc = in_valid && rdy;
      exp_fd = acc && (pix_cnt == img_w() * img_h() - 1);
      if (acc) begin
        void'(q_in.pop_front());
        pix_cnt = (pix_cnt + 1) % (img_w() * img_h());
        acc_cnt++;
      end
      stalled_prev = ov && !out_ready;
      prev_od = od;
      if (max_acc >= 0 && acc_cnt == max_acc) break;
      if (max_acc < 0 && q_in.size() == 0 && q_exp.size() == 0 && !exp_fd) break;
    end
    if (cyc == 4000) chk("timeout_pending", q_in.size() + q_exp.size(), 0);
  endtask

  task automatic abort_state();
    q_in.delete();
    q_exp.delete();
    pix_cnt = 0;
    exp_fd = 1'b0;
    stalled_prev = 1'b0;
  endtask

  initial begin
    int f[$];
    rst = 1'b1; clear = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov4, 1'b0);
    chk("rst_out_data", od4, 32'd0);
    chk("rst_frame_done", fd4, 1'b0);
    chk("rst_in_ready", rdy4, 1'b1);
    chk("rst_out_valid5", ov5, 1'b0);
    rst = 1'b0;

    // ramp 4x4: 5,7,13,15
    push_ramp();
    run(100, 100, -1);

    // signed window and an all-equal window
    for (int i = 0; i < 16; i++) f.push_back(int'($urandom));
    f[0] = -8; f[1] = -3; f[4] = -1; f[5] = -20;
    f[2] = 7;  f[3] = 7;  f[6] = 7;  f[7] = 7;
    push_frame(f);
    run(100, 100, -1);

    // backpressure with the ramp
    push_ramp();
    run(100, 25, -1);

    // 5x5: 6,8,16,18, odd tails dropped
    sel = 1'b1;
    push_ramp();
    run(100, 100, -1);
    repeat (3) push_random();
    run(70, 60, -1);

    // back-to-back frames
    sel = 1'b0;
    push_ramp();
    push_ramp();
    run(100, 100, -1);

    // clear after 6 pixels, with a beat offered in the clear cycle
    push_ramp();
    run(100, 100, 6);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd99;
    @(negedge clk);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clear_out_valid", ov4, 1'b0);
    chk("clear_frame_done", fd4, 1'b0);
    abort_state();
    push_ramp();
    run(100, 100, -1);

    // async reset mid-frame
    push_ramp();
    run(100, 100, 6);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    #2;
    chk("midrst_out_valid", ov4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    abort_state();
    push_ramp();
    run(100, 100, -1);

    // random frames on both sizes
    repeat (5) push_random();
    run(80, 70, -1);
    sel = 1'b1;
    repeat (2) push_random();
    run(90, 50, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
